dbg_mem_probe: RTL and testbench
================================

# dbg_mem_probe

- Debug read-back responder inside `toplevel`: serves the byte-wide debug port that a host or bench drives with command and address bytes.
- Decodes the entry sequence, reads the addressed words from data memory through a dedicated read port, and returns each word on a 32-bit output with a one-cycle valid pulse.
- Sits between the external debug pins and the data-memory debug read port; does not touch the CPU pipeline.

## Interface
Parameters:
- `ADDR_W`, 10: data-memory address width, must be ≥ 8.
- `MEM_LAT`, 1: memory read latency in cycles, range 1..4.
- `CMD_ENTER`, 8'h14: first byte of the entry sequence.
- `CMD_DUMP`, 8'h01: second byte of the entry sequence.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `data_in` in 8: command, length or address byte.
- `din_vld` in 1: `data_in` is sampled on every edge where this is high.
- `data_out` out 32: returned memory word.
- `data_out_vld` out 1: one-cycle pulse, `data_out` is new.
- `mem_addr` out ADDR_W: read address, zero-extended from the byte.
- `mem_rd` out 1: one-cycle read request.
- `mem_rdata` in 32: read data, valid MEM_LAT edges after `mem_rd` is sampled.
- `busy` out 1: high in WAIT.
- `ovr` out 1: sticky flag, a strobe was dropped.

## Operation
- Reset values: every output is 0; state is IDLE; length counter and `inf` are 0.
- States and transitions:
  - IDLE: strobe with `CMD_ENTER` → ARM. Any other byte is ignored.
  - ARM: strobe with `CMD_DUMP` → LEN. Strobe with `CMD_ENTER` stays in ARM. Any other byte → IDLE.
  - LEN: strobe loads `remaining` ← byte and sets `inf` = (byte == 0), then → DUMP.
  - DUMP: strobe sets `mem_addr` ← byte, pulses `mem_rd`, loads the latency counter, then → WAIT. Command values are not special here; every byte is an address.
  - WAIT: the counter runs down. At the capture edge, `data_out` ← `mem_rdata` and `data_out_vld` pulses. Unless `inf` is set, `remaining` decrements. If the result is 0 → IDLE, otherwise → DUMP.
- Length 0 means streaming: the block stays in DUMP/WAIT until reset.
- A strobe arriving in WAIT, including on the capture edge, is dropped and sets `ovr`.
- `ovr` clears on entry to ARM and on reset.
- `mem_addr` holds its value between reads.

## Timing
- Address strobe sampled at edge k:
  - `mem_rd` and `mem_addr` are high/valid between edge k and edge k+1.
  - Capture happens at edge k+MEM_LAT+1.
  - `data_out_vld` is high for exactly one cycle after the capture edge.
- Minimum spacing between accepted address strobes is MEM_LAT+2 edges. For MEM_LAT=1 that is an address every 3 cycles.
- `busy` is high from edge k+1 through the capture edge.
- Reset asserted mid-read: all outputs go to 0 immediately (asynchronous). The outstanding `mem_rdata` is ignored. The block returns to IDLE.
- Strobe on the edge that leaves WAIT for DUMP: dropped, per the WAIT rule.

## Configuration
- `DBG_PROBE_HOLD_EN`:
  - Defined: `data_out` holds the last captured word until the next capture or reset.
  - Undefined: `data_out` is 0 whenever `data_out_vld` is low.
  - `data_out_vld` timing is identical in both builds.

## Structure
- Shared package `dbg_probe_pkg`:
  - State enum: IDLE, ARM, LEN, DUMP, WAIT.
  - Default command constants `CMD_ENTER_DEF` = 8'h14 and `CMD_DUMP_DEF` = 8'h01.
  - Width constant for the 32-bit word.
- No sub-module. The FSM, latency counter and length counter are small enough to live in one module.

## Test plan
- Basic read, MEM_LAT=1, mem[5]=32'hDEADBEEF, mem[6]=32'h00000007. Strobes 14, 01, 02, 05, then 06 after 3 cycles:
  - `mem_addr` is 10'h005, then 10'h006.
  - `data_out` is DEADBEEF, then 00000007, each pulse 2 edges after its strobe.
  - State returns to IDLE.
- Bad entry: strobes 14, 07, then 05 → no `mem_rd` ever; state is IDLE.
- Overrun, MEM_LAT=3: length 1, address strobe 09, second strobe 1 cycle later:
  - Exactly one `mem_rd`.
  - `ovr` = 1 and stays 1.
  - A new 14, 01 sequence clears `ovr`.
- Streaming: length 0, then 300 addresses spaced 3 cycles apart → 300 `data_out_vld` pulses and still in DUMP.
- Reset mid-read, MEM_LAT=4: `rst` low 2 cycles after an address strobe → every output 0 immediately; no `data_out_vld`; IDLE after release.
- Hold build, with and without `DBG_PROBE_HOLD_EN`: read word A5A5A5A5 and check `data_out` 5 cycles later:
  - Defined: still A5A5A5A5.
  - Undefined: 0.

Source files
------------

// File: rtl/dbg_probe_pkg.sv
// Shared types and constants for the debug memory probe.
package dbg_probe_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam logic [7:0]  CMD_ENTER_DEF = 8'h14;
  localparam logic [7:0]  CMD_DUMP_DEF  = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LEN,
    DUMP,
    WAIT
  } state_t;

endpackage

// File: rtl/dbg_mem_probe.sv
// Debug read-back responder: decodes enter/dump/length bytes, then reads one memory word per address byte.
// Build option: DBG_PROBE_HOLD_EN keeps data_out at the last captured word instead of zeroing it.
module dbg_mem_probe
  import dbg_probe_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_LAT   = 1,
  parameter logic [7:0]  CMD_ENTER = CMD_ENTER_DEF,
  parameter logic [7:0]  CMD_DUMP  = CMD_DUMP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              din_vld,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_vld,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              ovr
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t     state, state_nxt;
  logic [2:0] lat_cnt;
  logic [7:0] remaining;
  logic [7:0] rem_dec;
  logic       inf;
  logic       load_len, issue, capture, drop, arm_entry;

  assign rem_dec = remaining - 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_len  = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    arm_entry = 1'b0;
    case (state)
      IDLE: begin
        if (din_vld && data_in == CMD_ENTER) begin
          state_nxt = ARM;
          arm_entry = 1'b1;
        end
      end
      ARM: begin
        if (din_vld) begin
          if (data_in == CMD_DUMP) begin
            state_nxt = LEN;
          end else if (data_in == CMD_ENTER) begin
            arm_entry = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      LEN: begin
        if (din_vld) begin
          load_len  = 1'b1;
          state_nxt = DUMP;
        end
      end
      DUMP: begin
        if (din_vld) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        drop = din_vld;
        if (lat_cnt == '0) begin
          capture = 1'b1;
          // Streaming (inf) never counts down, so it never returns to IDLE.
          if (!inf && rem_dec == '0) state_nxt = IDLE;
          else                       state_nxt = DUMP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out     <= '0;
      data_out_vld <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      busy         <= 1'b0;
      ovr          <= 1'b0;
      lat_cnt      <= '0;
      remaining    <= '0;
      inf          <= 1'b0;
    end else begin
      data_out_vld <= capture;
      mem_rd       <= issue;
      // Registered so busy rises one edge after the address strobe and falls at capture.
      busy         <= (state == WAIT) && (state_nxt == WAIT);

      if (issue) begin
        mem_addr <= ADDR_W'(data_in);
        lat_cnt  <= LAT_INIT;
      end else if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end

      if (load_len) begin
        remaining <= data_in;
        inf       <= (data_in == '0);
      end else if (capture && !inf) begin
        remaining <= rem_dec;
      end

      if (arm_entry)  ovr <= 1'b0;
      else if (drop)  ovr <= 1'b1;

`ifdef DBG_PROBE_HOLD_EN
      if (capture) data_out <= mem_rdata;
`else
      data_out <= capture ? mem_rdata : '0;
`endif
    end
  end

endmodule

// File: tb/tb_dbg_mem_probe.sv
// Scoreboard bench for dbg_mem_probe: three instances at MEM_LAT 1, 3 and 4 with a shared memory model.
module tb_dbg_mem_probe;
  import dbg_probe_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [N];
  logic [7:0]  din      [N];
  logic        dvld     [N];
  logic [31:0] dout     [N];
  logic        dout_vld [N];
  logic [9:0]  maddr    [N];
  logic        mrd      [N];
  logic [31:0] rdata    [N];
  logic        busy     [N];
  logic        ovr      [N];
  state_t      st       [N];

  logic [31:0] mem  [1024];
  logic [31:0] pipe [N][4];
  int          cyc;
  int          checks;
  int          errors;
  int          rd_cnt  [N];
  int          vld_cnt [N];
  exp_t        exp_q   [N][$];

  dbg_mem_probe #(.ADDR_W(10), .MEM_LAT(1), .CMD_ENTER(8'h14), .CMD_DUMP(8'h01)) u_dut0 (
    .clk(clk), .rst(rst_n[0]), .data_in(din[0]), .din_vld(dvld[0]),
    .data_out(dout[0]), .data_out_vld(dout_vld[0]), .mem_addr(maddr[0]), .mem_rd(mrd[0]),
    .mem_rdata(rdata[0]), .busy(busy[0]), .ovr(ovr[0]));

  dbg_mem_probe #(.ADDR_W(10), .MEM_LAT(3), .CMD_ENTER(8'h14), .CMD_DUMP(8'h01)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .data_in(din[1]), .din_vld(dvld[1]),
    .data_out(dout[1]), .data_out_vld(dout_vld[1]), .mem_addr(maddr[1]), .mem_rd(mrd[1]),
    .mem_rdata(rdata[1]), .busy(busy[1]), .ovr(ovr[1]));

  dbg_mem_probe #(.ADDR_W(10), .MEM_LAT(4), .CMD_ENTER(8'h14), .CMD_DUMP(8'h01)) u_dut2 (
    .clk(clk), .rst(rst_n[2]), .data_in(din[2]), .din_vld(dvld[2]),
    .data_out(dout[2]), .data_out_vld(dout_vld[2]), .mem_addr(maddr[2]), .mem_rd(mrd[2]),
    .mem_rdata(rdata[2]), .busy(busy[2]), .ovr(ovr[2]));

  assign st[0] = u_dut0.state;
  assign st[1] = u_dut1.state;
  assign st[2] = u_dut2.state;

  // Memory model: a read request sampled at an edge appears on rdata LAT edges later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (mrd[i]) pipe[i][0] <= mem[maddr[i]];
      for (int s = 1; s < 4; s++) pipe[i][s] <= pipe[i][s-1];
    end
  end

  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];
  assign rdata[2] = pipe[2][3];

  function automatic int lat_of(int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // Monitor: samples 2 ns after each rising edge and pops the scoreboard on every valid pulse.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (mrd[i]) rd_cnt[i]++;
      if (dout_vld[i]) begin
        vld_cnt[i]++;
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld dut%0d got %h at cyc %0d expected no pulse", i, dout[i], cyc);
        end else begin
          e = exp_q[i].pop_front();
          if (dout[i] !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL read_data dut%0d got %h at cyc %0d expected %h at cyc %0d",
                     i, dout[i], cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; the byte is sampled at the next rising edge.
  task automatic strobe(int i, logic [7:0] b, bit push);
    exp_t e;
    din[i]  = b;
    dvld[i] = 1'b1;
    @(negedge clk);
    dvld[i] = 1'b0;
    if (push) begin
      e.data = mem[{2'b00, b}];
      e.cyc  = cyc + lat_of(i) + 1;
      exp_q[i].push_back(e);
    end
  endtask

  task automatic chk_outputs_zero(int i, string tag);
    chk($sformatf("%s_dout%0d", tag, i), dout[i], 32'h0);
    chk($sformatf("%s_vld%0d", tag, i), 32'(dout_vld[i]), 32'h0);
    chk($sformatf("%s_addr%0d", tag, i), 32'(maddr[i]), 32'h0);
    chk($sformatf("%s_rd%0d", tag, i), 32'(mrd[i]), 32'h0);
    chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'h0);
    chk($sformatf("%s_ovr%0d", tag, i), 32'(ovr[i]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      din[i]   = 8'h00;
      dvld[i]  = 1'b0;
    end
    for (int a = 0; a < 1024; a++) mem[a] = 32'hC0DE0000 | 32'(a);
    mem[10'h005] = 32'hDEADBEEF;
    mem[10'h006] = 32'h00000007;
    mem[10'h009] = 32'h12345678;
    mem[10'h020] = 32'hCAFEF00D;
    mem[10'h033] = 32'hA5A5A5A5;

    idle(3);
    for (int i = 0; i < N; i++) begin
      chk_outputs_zero(i, "reset");
      chk($sformatf("reset_state%0d", i), 32'(st[i]), 32'(IDLE));
    end
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    idle(1);

    // Basic read, MEM_LAT=1
    strobe(0, 8'h14, 0);
    strobe(0, 8'h01, 0);
    strobe(0, 8'h02, 0);
    strobe(0, 8'h05, 1);
    chk("basic_addr5", 32'(maddr[0]), 32'h005);
    chk("basic_rd5", 32'(mrd[0]), 32'h1);
    idle(2);
    strobe(0, 8'h06, 1);
    chk("basic_addr6", 32'(maddr[0]), 32'h006);
    idle(1);
    chk("basic_busy", 32'(busy[0]), 32'h1);
    idle(3);
    chk("basic_state", 32'(st[0]), 32'(IDLE));
    chk("basic_addr_hold", 32'(maddr[0]), 32'h006);

    // Bad entry on the MEM_LAT=3 instance
    strobe(1, 8'h14, 0);
    strobe(1, 8'h07, 0);
    strobe(1, 8'h05, 0);
    idle(4);
    chk("bad_rd_count", 32'(rd_cnt[1]), 32'h0);
    chk("bad_state", 32'(st[1]), 32'(IDLE));

    // Overrun: second strobe one cycle after the address is dropped
    strobe(1, 8'h14, 0);
    strobe(1, 8'h01, 0);
    strobe(1, 8'h01, 0);
    strobe(1, 8'h09, 1);
    strobe(1, 8'h0A, 0);
    idle(6);
    chk("ovr_rd_count", 32'(rd_cnt[1]), 32'h1);
    chk("ovr_set", 32'(ovr[1]), 32'h1);
    chk("ovr_state", 32'(st[1]), 32'(IDLE));
    idle(3);
    chk("ovr_sticky", 32'(ovr[1]), 32'h1);
    strobe(1, 8'h14, 0);
    chk("ovr_clear", 32'(ovr[1]), 32'h0);
    strobe(1, 8'h01, 0);
    chk("ovr_len_state", 32'(st[1]), 32'(LEN));

    // Reset in the middle of a MEM_LAT=4 read
    strobe(2, 8'h14, 0);
    strobe(2, 8'h01, 0);
    strobe(2, 8'h01, 0);
    strobe(2, 8'h20, 0);
    chk("rst_pre_addr", 32'(maddr[2]), 32'h020);
    idle(1);
    chk("rst_pre_busy", 32'(busy[2]), 32'h1);
    @(posedge clk);
    #3;
    rst_n[2] = 1'b0;
    #1;
    chk_outputs_zero(2, "midrst");
    idle(2);
    rst_n[2] = 1'b1;
    idle(6);
    chk("midrst_state", 32'(st[2]), 32'(IDLE));
    chk("midrst_no_vld", 32'(vld_cnt[2]), 32'h0);

    // Streaming: length 0, 300 addresses at the minimum spacing
    strobe(0, 8'h14, 0);
    strobe(0, 8'h01, 0);
    strobe(0, 8'h00, 0);
    v0 = vld_cnt[0];
    for (int a = 0; a < 300; a++) begin
      strobe(0, 8'(a), 1);
      idle(2);
    end
    idle(1);
    chk("stream_pulses", 32'(vld_cnt[0] - v0), 32'd300);
    chk("stream_state", 32'(st[0]), 32'(DUMP));

    // data_out behaviour after the pulse
    rst_n[0] = 1'b0;
    idle(2);
    rst_n[0] = 1'b1;
    idle(1);
    strobe(0, 8'h14, 0);
    strobe(0, 8'h01, 0);
    strobe(0, 8'h01, 0);
    strobe(0, 8'h33, 1);
    idle(7);
    chk("hold_vld_low", 32'(dout_vld[0]), 32'h0);
`ifdef DBG_PROBE_HOLD_EN
    chk("hold_dout", dout[0], 32'hA5A5A5A5);
`else
    chk("hold_dout", dout[0], 32'h00000000);
`endif

    idle(2);
    for (int i = 0; i < N; i++)
      chk($sformatf("queue_empty%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
